// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the cache controller / refill controller pair:
//   - default widths (ADDR_W, DATA_W, TAG_W, SEL_W) and the refill TIMEOUT
//   - refill FSM state encoding (S_IDLE .. S_ERR)
//   - tag_of(): extracts the tag field from a CPU address
// ---------------------------------------------------------------------------
package cc_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TAG_W   = 6;
    localparam int SEL_W   = 3;
    localparam int TIMEOUT = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_FILL = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Tag is the upper TAG_W bits of the address.
    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/cc_victim_sel.sv
// ---------------------------------------------------------------------------
// cc_victim_sel
// Purely combinational victim-way picker for the fully associative cache.
// Picks the lowest-index invalid way; when every way is valid, the
// round-robin pointer is used instead.
// Ports:
//   i_valid_mask  in   2**SEL_W  per-way valid bits
//   i_rr_ptr      in   SEL_W     round-robin pointer
//   o_victim      out  SEL_W     way to fill
//   o_all_valid   out  1         every way is valid (victim came from rr_ptr)
// ---------------------------------------------------------------------------
module cc_victim_sel #(
    parameter int SEL_W = 3
) (
    input  logic [(2**SEL_W)-1:0] i_valid_mask,
    input  logic [SEL_W-1:0]      i_rr_ptr,
    output logic [SEL_W-1:0]      o_victim,
    output logic                  o_all_valid
);

    localparam int NWAYS = 2**SEL_W;

    logic [SEL_W-1:0] w_first_free;

    // Scan from the top down so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        w_first_free = '0;
        for (int i = NWAYS - 1; i >= 0; i--) begin
            if (!i_valid_mask[i]) begin
                w_first_free = SEL_W'(i);
            end
        end
    end

    assign o_all_valid = &i_valid_mask;
    assign o_victim    = o_all_valid ? i_rr_ptr : w_first_free;

endmodule

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
// Miss-handling stage behind cache_controller. On start&&miss it latches the
// address, fetches one byte from memory over a level req / single-cycle ack
// handshake, then issues a one-cycle write into the L1 data and tag arrays at
// the chosen victim way. Keeps the per-way valid bits and round-robin pointer.
//
// Optional feature macro: CC_REFILL_TIMEOUT_EN
//   defined   : REQ gives up after TIMEOUT cycles without mem_ack, pulses
//               refill_err for one cycle (state ERR) and returns to IDLE.
//   undefined : REQ waits indefinitely; refill_err is tied low.
//
// Ports:
//   CC_clk, rst_n          clock, asynchronous active-low reset
//   start, miss, address   cache enable, miss flag and CPU address
//   mem_req/mem_addr       memory read request (level) and latched address
//   mem_ack/mem_rdata      memory acknowledge with same-cycle read data
//   write_enable_L1        one-cycle fill strobe (only in FILL)
//   write_select           victim way, write_data_L1 fill byte, write_data_TA fill tag
//   valid_mask             per-way valid bits
//   busy                   refill in progress (REQ/FILL)
//   refill_done            one-cycle pulse in DONE
//   refill_err             one-cycle pulse in ERR (timeout build only)
// ---------------------------------------------------------------------------
module cache_refill_ctrl
    import cc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 6,
    parameter int SEL_W  = 3
`ifdef CC_REFILL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                  CC_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  miss,
    input  logic [ADDR_W-1:0]     address,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  write_enable_L1,
    output logic [SEL_W-1:0]      write_select,
    output logic [DATA_W-1:0]     write_data_L1,
    output logic [TAG_W-1:0]      write_data_TA,
    output logic [(2**SEL_W)-1:0] valid_mask,
    output logic                  busy,
    output logic                  refill_done,
    output logic                  refill_err
);

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;
    logic [(2**SEL_W)-1:0]  r_valid;
    logic [SEL_W-1:0]       r_rr;
    logic [SEL_W-1:0]       w_victim;
    logic                   w_all_valid;

`ifdef CC_REFILL_TIMEOUT_EN
    logic [7:0]             r_wait;
    logic                   w_timeout;

    // r_wait counts completed REQ cycles; the last allowed one triggers ERR.
    assign w_timeout = (r_wait == 8'(TIMEOUT - 1));

    always_ff @(posedge CC_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (r_state == S_REQ) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= '0;
        end
    end
`endif

    cc_victim_sel #(
        .SEL_W (SEL_W)
    ) u_victim_sel (
        .i_valid_mask (r_valid),
        .i_rr_ptr     (r_rr),
        .o_victim     (w_victim),
        .o_all_valid  (w_all_valid)
    );

    // State register plus the datapath latches that only move in one state.
    always_ff @(posedge CC_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start && miss) begin
                        r_addr <= address;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_data <= mem_rdata;
                    end
                end
                S_FILL: begin
                    r_valid[w_victim] <= 1'b1;
                    // rr_ptr only advances when the victim actually came from it.
                    if (w_all_valid) begin
                        r_rr <= r_rr + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and all control outputs decode from the registered state,
    // so reset forces every output low without waiting for a clock edge.
    always_comb begin
        w_next          = r_state;
        mem_req         = 1'b0;
        busy            = 1'b0;
        write_enable_L1 = 1'b0;
        write_select    = '0;
        write_data_L1   = '0;
        write_data_TA   = '0;
        refill_done     = 1'b0;
        refill_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && miss) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    w_next = S_FILL;
                end
`ifdef CC_REFILL_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next = S_ERR;
                end
`endif
            end
            S_FILL: begin
                busy            = 1'b1;
                write_enable_L1 = 1'b1;
                write_select    = w_victim;
                write_data_L1   = r_data;
                write_data_TA   = r_addr[ADDR_W-1 -: TAG_W];
                w_next          = S_DONE;
            end
            S_DONE: begin
                refill_done = 1'b1;
                w_next      = S_IDLE;
            end
            S_ERR: begin
`ifdef CC_REFILL_TIMEOUT_EN
                refill_err = 1'b1;
`endif
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign mem_addr   = r_addr;
    assign valid_mask = r_valid;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Directed stimulus; expected fills are queued by the stimulus and a
// separate monitor pops/compares them on every write strobe.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;

    logic       CC_clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       miss;
    logic [7:0] address;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       write_enable_L1;
    logic [2:0] write_select;
    logic [7:0] write_data_L1;
    logic [5:0] write_data_TA;
    logic [7:0] valid_mask;
    logic       busy;
    logic       refill_done;
    logic       refill_err;

    typedef struct packed {
        logic [2:0] sel;
        logic [5:0] tag;
        logic [7:0] data;
    } fill_t;

    fill_t exp_q[$];
    int    n_total       = 0;
    int    n_pass        = 0;
    int    n_strobes     = 0;
    int    n_exp_strobes = 0;

    cache_refill_ctrl dut (
        .CC_clk          (CC_clk),
        .rst_n           (rst_n),
        .start           (start),
        .miss            (miss),
        .address         (address),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .write_enable_L1 (write_enable_L1),
        .write_select    (write_select),
        .write_data_L1   (write_data_L1),
        .write_data_TA   (write_data_TA),
        .valid_mask      (valid_mask),
        .busy            (busy),
        .refill_done     (refill_done),
        .refill_err      (refill_err)
    );

    always #5 CC_clk = ~CC_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest queued fill.
    always @(negedge CC_clk) begin
        if (write_enable_L1 === 1'b1) begin
            fill_t e;
            n_strobes++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got sel=%0d tag=%0d data=0x%0h expected no strobe at %0t",
                         write_select, write_data_TA, write_data_L1, $time);
            end else begin
                e = exp_q.pop_front();
                chk("fill_sel",  {29'd0, write_select},  {29'd0, e.sel});
                chk("fill_tag",  {26'd0, write_data_TA}, {26'd0, e.tag});
                chk("fill_data", {24'd0, write_data_L1}, {24'd0, e.data});
                $display("fill: sel=%0d tag=%0d data=0x%0h", write_select, write_data_TA, write_data_L1);
            end
        end
    end

    task automatic do_reset();
        @(posedge CC_clk); #1;
        rst_n = 1'b0;
        @(negedge CC_clk);
        rst_n = 1'b1;
    endtask

    // One full refill: miss, ack after nwait REQ cycles, then FILL and DONE.
    task automatic do_miss(input logic [7:0] addr, input int nwait, input logic [7:0] rdata,
                           input logic [2:0] exp_sel, input logic [7:0] exp_mask);
        logic [7:0] a;
        a = addr;
        @(posedge CC_clk); #1;
        start = 1'b1; miss = 1'b1; address = addr;
        @(posedge CC_clk); #1;
        miss = 1'b0; address = 8'hFF;
        chk("req_mem_req", {31'd0, mem_req}, 32'd1);
        chk("req_mem_addr", {24'd0, mem_addr}, {24'd0, a});
        chk("req_busy", {31'd0, busy}, 32'd1);
        repeat (nwait) begin
            @(posedge CC_clk); #1;
        end
        exp_q.push_back('{sel: exp_sel, tag: a[7:2], data: rdata});
        n_exp_strobes++;
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge CC_clk); #1;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("fill_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge CC_clk); #1;
        chk("done_pulse", {31'd0, refill_done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_valid_mask", {24'd0, valid_mask}, {24'd0, exp_mask});
        $display("miss: addr=%0d wait=%0d rdata=0x%0h mask=0x%0h", addr, nwait, rdata, valid_mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; miss = 1'b0; address = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;

        // 1: reset values, then idle with no miss
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_we", {31'd0, write_enable_L1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, refill_done}, 32'd0);
        chk("rst_err", {31'd0, refill_err}, 32'd0);
        chk("rst_valid_mask", {24'd0, valid_mask}, 32'd0);
        @(negedge CC_clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge CC_clk); #1;
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
        $display("reset: done");

        // 2: cold miss, ack after 3 cycles
        do_miss(8'd104, 3, 8'hA5, 3'd0, 8'h01);

        // 3: eight cold misses fill ways 0..7, then rr wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_miss(8'(i * 32 + 3), i % 3, 8'(8'h10 + i), 3'(i), 8'((9'd1 << (i + 1)) - 9'd1));
        end
        do_miss(8'd45, 1, 8'h5A, 3'd0, 8'hFF);
        do_miss(8'd250, 2, 8'hC3, 3'd1, 8'hFF);

        // 4: miss held through REQ/FILL/DONE with a changing address, stray ack in IDLE
        @(posedge CC_clk); #1;
        miss = 1'b1; address = 8'd200;
        @(posedge CC_clk); #1;
        address = 8'd7;
        chk("hold_mem_addr", {24'd0, mem_addr}, 32'd200);
        exp_q.push_back('{sel: 3'd2, tag: 6'd50, data: 8'h3C});
        n_exp_strobes++;
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        @(posedge CC_clk); #1;
        mem_ack = 1'b0;
        @(posedge CC_clk); #1;
        chk("hold_done", {31'd0, refill_done}, 32'd1);
        @(posedge CC_clk); #1;
        miss = 1'b0;
        chk("hold_idle_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1;
        repeat (2) begin
            @(posedge CC_clk); #1;
        end
        mem_ack = 1'b0;
        chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
        chk("stray_ack_busy", {31'd0, busy}, 32'd0);
        chk("stray_mem_addr", {24'd0, mem_addr}, 32'd200);
        $display("ignore: miss-in-busy and stray ack handled");

        // 5: asynchronous reset in REQ
        @(posedge CC_clk); #1;
        miss = 1'b1; address = 8'd33;
        @(posedge CC_clk); #1;
        miss = 1'b0;
        chk("arst_pre_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_we", {31'd0, write_enable_L1}, 32'd0);
        chk("arst_valid_mask", {24'd0, valid_mask}, 32'd0);
        @(negedge CC_clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge CC_clk); #1;
        end
        chk("arst_after_req", {31'd0, mem_req}, 32'd0);
        $display("async reset: mem_req dropped");

`ifdef CC_REFILL_TIMEOUT_EN
        // 6: timeout with no ack
        do_miss(8'd104, 0, 8'hA5, 3'd0, 8'h01);
        @(posedge CC_clk); #1;
        miss = 1'b1; address = 8'd77;
        @(posedge CC_clk); #1;
        miss = 1'b0;
        repeat (15) begin
            @(posedge CC_clk); #1;
        end
        chk("to_before_err", {31'd0, refill_err}, 32'd0);
        chk("to_before_req", {31'd0, mem_req}, 32'd1);
        @(posedge CC_clk); #1;
        chk("to_err", {31'd0, refill_err}, 32'd1);
        chk("to_err_req", {31'd0, mem_req}, 32'd0);
        chk("to_valid_mask", {24'd0, valid_mask}, 32'h01);
        @(posedge CC_clk); #1;
        chk("to_err_pulse", {31'd0, refill_err}, 32'd0);
        chk("to_idle_busy", {31'd0, busy}, 32'd0);
        $display("timeout: refill_err pulsed");
`endif

        repeat (2) @(posedge CC_clk);
        #1;
        chk("strobe_count", 32'(n_strobes), 32'(n_exp_strobes));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
